// File: rtl/btc_job_sequencer_pkg.sv
// Shared definitions for the BTC job sequencer: header word map, FSM states,
// result entry layout and SHA-256 padding constants for the core wrapper.
package btc_job_sequencer_pkg;

  localparam int unsigned HDR_WORDS        = 20;
  localparam int unsigned HDR_VERSION      = 0;
  localparam int unsigned HDR_PREV_HASH0   = 1;
  localparam int unsigned HDR_MERKLE_ROOT0 = 9;
  localparam int unsigned HDR_BTIME        = 17;
  localparam int unsigned HDR_BITS         = 18;
  localparam int unsigned HDR_NONCE        = 19;
  localparam int unsigned HASH_WORDS       = 8;

  // 640-bit header hashed as two blocks; the core wrapper appends these.
  localparam logic [31:0] SHA_PAD_WORD        = 32'h8000_0000;
  localparam logic [31:0] SHA_HDR_LEN_BITS    = 32'd640;
  localparam logic [31:0] SHA_DIGEST_LEN_BITS = 32'd256;

  localparam int unsigned RES_WIDTH = 40;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LAUNCH,
    ST_ARM,
    ST_RUN
  } seq_state_t;

  typedef struct packed {
    logic [31:0] nonce;
    logic [7:0]  job_id;
  } res_entry_t;

  function automatic logic [31:0] nonce_next(input logic [31:0] n);
    return n + 32'd1;
  endfunction

endpackage

// File: rtl/btc_job_sequencer_if.sv
// Header-write and result-read handshakes of the BTC job sequencer.
interface btc_job_sequencer_if;
  logic        wr_valid;
  logic        wr_ready;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic        wr_commit;
  logic        res_valid;
  logic        res_ready;
  logic [31:0] res_nonce;
  logic [7:0]  res_job_id;

  modport master (
    output wr_valid, wr_addr, wr_data, wr_commit, res_ready,
    input  wr_ready, res_valid, res_nonce, res_job_id
  );

  modport slave (
    input  wr_valid, wr_addr, wr_data, wr_commit, res_ready,
    output wr_ready, res_valid, res_nonce, res_job_id
  );
endinterface

// File: rtl/btc_result_fifo.sv
// Found-nonce result FIFO: first-word fall-through, push accepted when full
// if a pop happens in the same cycle.
module btc_result_fifo #(
  parameter int unsigned WIDTH = 40,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             empty,
  output logic [WIDTH-1:0] head,
  output logic             drop
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             full;
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign drop    = push && full && !do_pop;
  assign head    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/btc_job_sequencer.sv
// Double-buffered block-header job sequencer: loads a shadow header, launches
// it on the miner core, optionally resumes after a find, and queues results.
module btc_job_sequencer
  import btc_job_sequencer_pkg::*;
#(
  parameter int unsigned RES_DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  btc_job_sequencer_if.slave      job_if,
  input  logic                    cfg_resume,
  output logic                    core_start,
  output logic [31:0]             core_version,
  output logic [255:0]            core_previous_hash,
  output logic [255:0]            core_merkle_root,
  output logic [31:0]             core_btime,
  output logic [31:0]             core_bits,
  output logic [31:0]             core_nonce_in,
  input  logic                    core_done,
  input  logic                    core_nonce_found,
  input  logic [31:0]             core_nonce_out,
  output logic                    busy,
  output logic                    pending,
  output logic                    overflow
);

  seq_state_t  state;
  seq_state_t  state_nxt;
  logic [31:0] shadow [HDR_WORDS];
  logic [31:0] active [HDR_WORDS];
  logic [7:0]  job_id;
  logic        pending_q;
  logic        overflow_q;
  logic        take_job;
  logic        resume_go;
  logic        wr_fire;
  logic        fifo_empty;
  logic        fifo_drop;
  logic [RES_WIDTH-1:0] fifo_head;
  res_entry_t  head_entry;

  assign job_if.wr_ready = !pending_q;
  assign wr_fire         = job_if.wr_valid && job_if.wr_ready;

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // RUN is only entered with core_done low, so core_done high in RUN is its rising edge.
  always_comb begin
    state_nxt  = state;
    take_job   = 1'b0;
    resume_go  = 1'b0;
    core_start = 1'b0;
    case (state)
      ST_IDLE: begin
        if (pending_q) begin
          take_job  = 1'b1;
          state_nxt = ST_LAUNCH;
        end
      end
      ST_LAUNCH: begin
        core_start = 1'b1;
        state_nxt  = ST_ARM;
      end
      ST_ARM: begin
        if (!core_done) state_nxt = ST_RUN;
      end
      ST_RUN: begin
        if (core_done) begin
          if (core_nonce_found && cfg_resume && !pending_q && (core_nonce_out != '1)) begin
            resume_go = 1'b1;
            state_nxt = ST_LAUNCH;
          end else begin
            state_nxt = ST_IDLE;
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < HDR_WORDS; i++) begin
        shadow[i] <= '0;
        active[i] <= '0;
      end
      job_id    <= '0;
      pending_q <= 1'b0;
    end else begin
      if (wr_fire && (job_if.wr_addr < 5'(HDR_WORDS)))
        shadow[job_if.wr_addr] <= job_if.wr_data;
      if (take_job) begin
        for (int unsigned i = 0; i < HDR_WORDS; i++) active[i] <= shadow[i];
        job_id    <= job_id + 8'd1;
        pending_q <= 1'b0;
      end else if (wr_fire && job_if.wr_commit) begin
        pending_q <= 1'b1;
      end
      if (resume_go) active[HDR_NONCE] <= nonce_next(core_nonce_out);
    end
  end

  always_ff @(posedge clk) begin
    if (rst)            overflow_q <= 1'b0;
    else if (fifo_drop) overflow_q <= 1'b1;
  end

  btc_result_fifo #(
    .WIDTH (RES_WIDTH),
    .DEPTH (RES_DEPTH)
  ) u_res_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (core_nonce_found),
    .push_data ({core_nonce_out, job_id}),
    .pop       (job_if.res_ready),
    .empty     (fifo_empty),
    .head      (fifo_head),
    .drop      (fifo_drop)
  );

  assign head_entry        = res_entry_t'(fifo_head);
  assign job_if.res_valid  = !fifo_empty;
  assign job_if.res_nonce  = head_entry.nonce;
  assign job_if.res_job_id = head_entry.job_id;

  for (genvar k = 0; k < HASH_WORDS; k++) begin : g_hash
    assign core_previous_hash[32*k +: 32] = active[HDR_PREV_HASH0 + k];
    assign core_merkle_root[32*k +: 32]   = active[HDR_MERKLE_ROOT0 + k];
  end

  assign core_version  = active[HDR_VERSION];
  assign core_btime    = active[HDR_BTIME];
  assign core_bits     = active[HDR_BITS];
  assign core_nonce_in = active[HDR_NONCE];
  assign busy          = (state != ST_IDLE);
  assign pending       = pending_q;
  assign overflow      = overflow_q;

endmodule
